// File: rtl/kernel_kcore_start_sched.sv
// Round-robin start-token scheduler feeding one kcore start FIFO write port, with a credit limit
// and a drain sequence. Optional per-requester grant statistics: KCORE_START_SCHED_STATS_EN.
module kernel_kcore_start_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 1,
  parameter int CREDIT_WIDTH = 3,
  localparam int SEL_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          drain_req,
  input  logic [CREDIT_WIDTH-1:0]       max_outstanding,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_full_n,
  input  logic                          done_pulse,
  output logic [CREDIT_WIDTH-1:0]       outstanding,
  output logic                          busy,
  output logic                          drain_done,
  output logic                          err_underflow,
  input  logic [SEL_WIDTH-1:0]          stat_sel,
  output logic [15:0]                   stat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CREDIT_WIDTH-1:0] outstanding_r;
  logic [CREDIT_WIDTH-1:0] outstanding_nxt_s;
  logic [SEL_WIDTH-1:0]    last_grant_r;
  logic [SEL_WIDTH-1:0]    grant_idx_s;
  logic [SEL_WIDTH-1:0]    cand_sel_s;
  int                      cand_s;
  logic                    grant_found_s;
  logic                    grant_ok_s;
  logic                    dec_ok_s;
  logic                    underflow_s;
  logic                    err_underflow_r;
  logic                    drain_done_r;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = last_grant_r;
    cand_s        = 0;
    cand_sel_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s        = (int'(last_grant_r) + k >= NUM_REQ) ? int'(last_grant_r) + k - NUM_REQ
                                                          : int'(last_grant_r) + k;
      cand_sel_s    = SEL_WIDTH'(cand_s);
      grant_idx_s   = (!grant_found_s && req_valid[cand_sel_s]) ? cand_sel_s : grant_idx_s;
      grant_found_s = grant_found_s | req_valid[cand_sel_s];
    end
  end

  assign grant_ok_s  = (state_r == ST_RUN) && fifo_full_n &&
                       (outstanding_r < max_outstanding) && grant_found_s;
  assign dec_ok_s    = done_pulse && (outstanding_r != '0);
  assign underflow_s = done_pulse && (outstanding_r == '0);

  // Mealy grant outputs: one-hot grant and the granted requester's token
  always_comb begin
    req_grant = '0;
    fifo_din  = '0;
    if (grant_ok_s) begin
      req_grant[grant_idx_s] = 1'b1;
      fifo_din               = req_data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      req_grant = '0;
      fifo_din  = '0;
    end
  end

  assign fifo_write = grant_ok_s;

  // Credit counter next value; a grant and a completion in the same cycle cancel out
  always_comb begin
    case ({grant_ok_s, dec_ok_s})
      2'b10:   outstanding_nxt_s = outstanding_r + CREDIT_WIDTH'(1);
      2'b01:   outstanding_nxt_s = outstanding_r - CREDIT_WIDTH'(1);
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Control FSM, credit counter, arbitration pointer and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      outstanding_r   <= '0;
      last_grant_r    <= SEL_WIDTH'(NUM_REQ - 1);
      err_underflow_r <= 1'b0;
      drain_done_r    <= 1'b0;
    end else begin
      outstanding_r <= outstanding_nxt_s;
      drain_done_r  <= 1'b0;
      if (grant_ok_s) begin
        last_grant_r <= grant_idx_s;
      end
      if (underflow_s) begin
        err_underflow_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (drain_req || !enable) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave as soon as this cycle's update brings the count to zero
          if (outstanding_nxt_s == '0) begin
            state_r      <= ST_IDLE;
            drain_done_r <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign outstanding   = outstanding_r;
  assign busy          = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign drain_done    = drain_done_r;
  assign err_underflow = err_underflow_r;

`ifdef KCORE_START_SCHED_STATS_EN
  logic [15:0] stat_r [NUM_REQ];

  // Saturating per-requester grant counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_r[i] <= 16'd0;
      end
    end else if (grant_ok_s && (stat_r[grant_idx_s] != 16'hFFFF)) begin
      stat_r[grant_idx_s] <= stat_r[grant_idx_s] + 16'd1;
    end
  end

  // Statistics read port; selects beyond the last requester read zero
  always_comb begin
    if (int'(stat_sel) < NUM_REQ) begin
      stat_cnt = stat_r[stat_sel];
    end else begin
      stat_cnt = 16'd0;
    end
  end
`else
  logic stat_sel_unused_s;
  assign stat_sel_unused_s = ^stat_sel;
  assign stat_cnt          = 16'd0;
`endif

endmodule

// File: tb/tb_kernel_kcore_start_sched.sv
// Self-checking bench for kernel_kcore_start_sched: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural scheduler model.
module tb_kernel_kcore_start_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        drain_req = 1'b0;
  logic [2:0]  max_outstanding = 3'd0;
  logic [3:0]  req_valid = 4'd0;
  logic [7:0]  req_data = 8'd0;
  logic [3:0]  req_grant;
  logic        fifo_write;
  logic [1:0]  fifo_din;
  logic        fifo_full_n = 1'b0;
  logic        done_pulse = 1'b0;
  logic [2:0]  outstanding;
  logic        busy;
  logic        drain_done;
  logic        err_underflow;
  logic [1:0]  stat_sel = 2'd0;
  logic [15:0] stat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: 0 idle, 1 run, 2 drain
  int m_state, m_out, m_last, m_err, m_dd;
  int m_stat [4];

  kernel_kcore_start_sched #(.NUM_REQ(4), .DATA_WIDTH(2), .CREDIT_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .drain_req(drain_req),
    .max_outstanding(max_outstanding), .req_valid(req_valid), .req_data(req_data),
    .req_grant(req_grant), .fifo_write(fifo_write), .fifo_din(fifo_din),
    .fifo_full_n(fifo_full_n), .done_pulse(done_pulse), .outstanding(outstanding),
    .busy(busy), .drain_done(drain_done), .err_underflow(err_underflow),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_out = 0; m_last = 3; m_err = 0; m_dd = 0;
    for (int i = 0; i < 4; i++) m_stat[i] = 0;
  endtask

  // Compare every output against the model, then advance the model across one clock edge
  task automatic cyc();
    bit   g;
    int   gi, nout, dec;
    logic [3:0]  eg;
    logic [1:0]  ed;
    logic [15:0] es;
    #1;
    g = 0; gi = 0;
    if (m_state == 1 && fifo_full_n && m_out < int'(max_outstanding) && req_valid != 4'd0) begin
      for (int k = 1; k <= 4; k++) begin
        if (!g && req_valid[(m_last + k) % 4]) begin
          g = 1; gi = (m_last + k) % 4;
        end
      end
    end
    eg = g ? 4'(1 << gi) : 4'd0;
    ed = g ? 2'((req_data >> (2 * gi)) & 8'h3) : 2'd0;
`ifdef KCORE_START_SCHED_STATS_EN
    es = 16'(m_stat[stat_sel]);
`else
    es = 16'd0;
`endif
    chk("req_grant", req_grant, eg);
    chk("fifo_write", fifo_write, g);
    chk("fifo_din", fifo_din, ed);
    chk("outstanding", outstanding, m_out);
    chk("busy", busy, m_state != 0);
    chk("drain_done", drain_done, m_dd);
    chk("err_underflow", err_underflow, m_err);
    chk("stat_cnt", stat_cnt, es);
    @(posedge clk);
    dec = (done_pulse && m_out > 0) ? 1 : 0;
    if (done_pulse && m_out == 0) m_err = 1;
    nout = m_out + (g ? 1 : 0) - dec;
    m_dd = 0;
    case (m_state)
      0: if (enable) m_state = 1;
      1: if (drain_req || !enable) m_state = 2;
      2: if (nout == 0) begin m_state = 0; m_dd = 1; end
      default: m_state = 0;
    endcase
    if (g) begin
      m_last = gi;
      if (m_stat[gi] < 65535) m_stat[gi]++;
    end
    m_out = nout;
    @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk("rst_req_grant", req_grant, 4'd0);
    chk("rst_fifo_write", fifo_write, 1'b0);
    chk("rst_fifo_din", fifo_din, 2'd0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_err_underflow", err_underflow, 1'b0);
    chk("rst_stat_cnt", stat_cnt, 16'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_reset_values();
    @(negedge clk);
    reset_n = 1'b1;

    // Fill all four credits with requesters 0..3 in turn
    max_outstanding = 3'd4; fifo_full_n = 1'b1; req_valid = 4'hF;
    req_data = 8'b00_11_01_10; enable = 1'b1;
    #1 chk("idle_to_run_no_grant", req_grant, 4'd0); cyc();
    #1 chk("g0", req_grant, 4'b0001); chk("g0_din", fifo_din, 2'd2); cyc();
    #1 chk("g1", req_grant, 4'b0010); chk("g1_din", fifo_din, 2'd1); cyc();
    #1 chk("g2", req_grant, 4'b0100); chk("g2_din", fifo_din, 2'd3); cyc();
    #1 chk("g3", req_grant, 4'b1000); chk("g3_din", fifo_din, 2'd0); cyc();
    #1 chk("credits_full", outstanding, 3'd4); chk("credits_block", req_grant, 4'd0); cyc();
    done_pulse = 1'b1;
    #1 chk("done_cycle_no_grant", req_grant, 4'd0); cyc();
    done_pulse = 1'b0;
    #1 chk("after_done_cnt", outstanding, 3'd3); chk("after_done_g0", req_grant, 4'b0001); cyc();
    #1 chk("refill_stop", req_grant, 4'd0); chk("refill_cnt", outstanding, 3'd4);

    // FIFO full blocks, release grants in the same cycle
    req_valid = 4'd0; done_pulse = 1'b1; cyc(); cyc(); done_pulse = 1'b0;
    fifo_full_n = 1'b0; req_valid = 4'hF;
    #1 chk("full_no_write", fifo_write, 1'b0); chk("full_no_grant", req_grant, 4'd0); cyc();
    fifo_full_n = 1'b1;
    #1 chk("unfull_grant", req_grant, 4'b0010); chk("unfull_write", fifo_write, 1'b1); cyc();

    // Grant and completion in the same cycle at a count of two
    req_valid = 4'd0; done_pulse = 1'b1; cyc();
    req_valid = 4'hF;
    #1 chk("simul_grant", req_grant, 4'b0100); cyc();
    done_pulse = 1'b0;
    #1 chk("simul_cnt", outstanding, 3'd2);
    cyc();

    // Drain from a count of three
    req_valid = 4'd0; drain_req = 1'b1; cyc(); drain_req = 1'b0;
    req_valid = 4'hF; done_pulse = 1'b1;
    #1 chk("drain_no_grant", req_grant, 4'd0); chk("drain_busy", busy, 1'b1); cyc();
    #1 chk("drain_dd_low", drain_done, 1'b0); cyc();
    cyc();
    done_pulse = 1'b0; enable = 1'b0;
    #1 chk("drain_done", drain_done, 1'b1); chk("drain_idle", busy, 1'b0);
    chk("drain_cnt", outstanding, 3'd0); cyc();
    #1 chk("drain_done_pulse", drain_done, 1'b0);

    // Underflow is sticky
    done_pulse = 1'b1; cyc(); done_pulse = 1'b0;
    #1 chk("underflow_set", err_underflow, 1'b1); chk("underflow_cnt", outstanding, 3'd0);
    cyc(); cyc();
    #1 chk("underflow_sticky", err_underflow, 1'b1);

    // Asynchronous reset in the middle of RUN with two tokens outstanding
    enable = 1'b1; max_outstanding = 3'd7; req_valid = 4'b0100; stat_sel = 2'd2;
    cyc(); cyc(); cyc();
    #1 chk("pre_reset_cnt", outstanding, 3'd2);
    reset_n = 1'b0;
    #1 chk_reset_values();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Five grants to requester 2
    cyc();
    repeat (5) cyc();
    req_valid = 4'd0;
`ifdef KCORE_START_SCHED_STATS_EN
    #1 chk("stat_req2", stat_cnt, 16'd5);
`else
    #1 chk("stat_tied", stat_cnt, 16'd0);
`endif
    chk("stat_cnt_out", outstanding, 3'd5);
    cyc();

    // Randomized traffic against the model
    max_outstanding = 3'd4;
    for (int n = 0; n < 3000; n++) begin
      enable      = ($urandom_range(0, 19) != 0);
      drain_req   = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) max_outstanding = 3'($urandom_range(0, 7));
      fifo_full_n = ($urandom_range(0, 4) != 0);
      req_valid   = 4'($urandom);
      req_data    = 8'($urandom);
      done_pulse  = (m_out > 0) && ($urandom_range(0, 2) == 0);
      stat_sel    = 2'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
